// File: rtl/dma_copy_engine_if.sv
// Purpose : bundles the CPU register port, the shared-SRAM master port and the
//           completion/status outputs of dma_copy_engine into one interface.
// Latency : wiring only.  Backpressure: the SRAM port is gated by bus_req/bus_gnt.
//
// Signal summary
//   reg_sel/reg_we/reg_wdata -> engine   CPU register select, write strobe, data
//   reg_rdata                <- engine   combinational register read-back
//   bus_req                  <- engine   request for the shared SRAM port
//   bus_gnt                  -> engine   grant from the arbiter
//   mem_addr/mem_re/mem_we   <- engine   SRAM byte address and strobes
//   mem_wdata                <- engine   SRAM write data
//   mem_rdata                -> engine   SRAM read data (valid the cycle after mem_re)
//   eop/busy                 <- engine   one-cycle completion pulse, transfer in progress
//
// Modports: master = the DMA engine side, slave = CPU / arbiter / SRAM side.
interface dma_copy_engine_if #(
    parameter int AW = 8,
    parameter int DW = 32
) ();
    logic [1:0]    reg_sel;
    logic          reg_we;
    logic [7:0]    reg_wdata;
    logic [7:0]    reg_rdata;
    logic          bus_req;
    logic          bus_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          eop;
    logic          busy;

    modport master (
        input  reg_sel,
        input  reg_we,
        input  reg_wdata,
        output reg_rdata,
        output bus_req,
        input  bus_gnt,
        output mem_addr,
        output mem_re,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        output eop,
        output busy
    );

    modport slave (
        output reg_sel,
        output reg_we,
        output reg_wdata,
        input  reg_rdata,
        input  bus_req,
        output bus_gnt,
        input  mem_addr,
        input  mem_re,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        input  eop,
        input  busy
    );
endinterface

// File: rtl/dma_copy_engine.sv
// Purpose : memory-to-memory copy engine on the shared SRAM port; copies LEN words src->dst.
// Latency : 5 cycles per word with immediate grant (REQ,RD,WT,WR,GAP), last GAP replaced by FIN/eop.
// Backpressure: waits in REQ holding bus_req until bus_gnt; drops bus_req one cycle per word.
//
// Ports
//   clk  : system clock, all state on posedge
//   rst  : synchronous active-high reset; aborts any transfer without further strobes
//   bus  : dma_copy_engine_if.master -- register port, SRAM master port, eop/busy
module dma_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic              clk,
    input  logic              rst,
    dma_copy_engine_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WT,
        S_WR,
        S_GAP,
        S_FIN
    } state_t;

    state_t state_q;
    state_t state_d;

    // Programmed registers (CPU visible) and working copies used by the copy loop.
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [LW-1:0] len_q;
    logic          done_q;
    logic [AW-1:0] cur_src;
    logic [AW-1:0] cur_dst;
    logic [LW-1:0] cnt;
    logic [DW-1:0] data_q;

    // Combinational outputs before they reach the interface.
    logic          bus_req;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          eop;
    logic          busy;
    logic [7:0]    reg_rdata;

    // Register writes only land while idle; a write during a transfer (or during
    // the FIN cycle) is silently dropped so the running copy cannot be disturbed.
    logic cfg_we;
    logic start;

    assign cfg_we = (state_q == S_IDLE) && bus.reg_we;
    assign start  = cfg_we && (bus.reg_sel == 2'd3) && bus.reg_wdata[0];

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            cur_src <= '0;
            cur_dst <= '0;
            cnt     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;

            if (cfg_we) begin
                case (bus.reg_sel)
                    2'd0:    src_q <= AW'({bus.reg_wdata[7:2], 2'b00});
                    2'd1:    dst_q <= AW'({bus.reg_wdata[7:2], 2'b00});
                    2'd2:    len_q <= LW'(bus.reg_wdata);
                    default: ;
                endcase
            end

            // Working copies are snapshotted at START so the programmed values
            // stay readable and reusable for a repeat transfer.
            if (start) begin
                done_q  <= 1'b0;
                cur_src <= src_q;
                cur_dst <= dst_q;
                cnt     <= len_q;
            end

            // SRAM returns read data the cycle after mem_re, i.e. during WT.
            if (state_q == S_WT) begin
                data_q <= bus.mem_rdata;
            end

            // Pointers wrap naturally at 2^AW.
            if (state_q == S_WR) begin
                cur_src <= cur_src + AW'(4);
                cur_dst <= cur_dst + AW'(4);
                cnt     <= cnt - LW'(1);
            end

            if (state_q == S_FIN) begin
                done_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bus_req   = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        eop       = 1'b0;
        busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len_q == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus.bus_gnt) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                bus_req  = 1'b1;
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = cur_src;
                state_d  = S_WT;
            end
            S_WT: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                bus_req   = 1'b1;
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cur_dst;
                mem_wdata = data_q;
                // cnt is decremented on this edge; a count of 1 means this was the last word.
                state_d   = (cnt == LW'(1)) ? S_FIN : S_GAP;
            end
            S_GAP: begin
                // bus_req dropped for one cycle so the CPU can win arbitration.
                busy    = 1'b1;
                state_d = S_REQ;
            end
            S_FIN: begin
                eop     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register read-back mux.
    always_comb begin
        reg_rdata = '0;
        case (bus.reg_sel)
            2'd0:    reg_rdata = 8'(src_q);
            2'd1:    reg_rdata = 8'(dst_q);
            2'd2:    reg_rdata = 8'(len_q);
            default: reg_rdata = {6'b0, done_q, busy};
        endcase
    end

    assign bus.bus_req   = bus_req;
    assign bus.mem_re    = mem_re;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.eop       = eop;
    assign bus.busy      = busy;
    assign bus.reg_rdata = reg_rdata;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: SRAM model, expected-operation queue built from
// plain copy semantics, a negedge compare process, and directed scenarios.
module tb_dma_copy_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_copy_engine_if #(.AW(8), .DW(32)) dif ();

    dma_copy_engine #(.AW(8), .DW(32), .LW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- SRAM model (64 words, byte address [7:2]) ----------------
    logic [31:0] sram     [0:63];
    logic [31:0] init_img [0:63];
    logic [31:0] exp_img  [0:63];
    logic        do_load = 1'b0;
    logic [31:0] rdata_q = 32'd0;

    always @(posedge clk) begin
        if (do_load) sram <= init_img;
        else if (dif.mem_we) sram[dif.mem_addr[7:2]] <= dif.mem_wdata;
        if (dif.mem_re) rdata_q <= sram[dif.mem_addr[7:2]];
    end
    assign dif.mem_rdata = rdata_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- expected operation stream ----------------
    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] dat;
    } op_t;

    op_t        exp_q[$];
    logic [7:0] rd_log[$];
    logic [7:0] wr_log[$];
    int eop_cnt      = 0;
    int eop_cyc      = -1;
    int strobe_cnt   = 0;
    int first_re_cyc = -1;

    // Compare process: every SRAM strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (cyc > 2) begin
            if (dif.eop) begin
                eop_cnt++;
                eop_cyc = cyc;
            end
            if (dif.mem_re || dif.mem_we) begin
                op_t op;
                strobe_cnt++;
                check("re_we_exclusive", 32'(dif.mem_re & dif.mem_we), 32'd0);
                check("req_with_strobe", 32'(dif.bus_req), 32'd1);
                if (dif.mem_re) begin
                    rd_log.push_back(dif.mem_addr);
                    if (first_re_cyc < 0) first_re_cyc = cyc;
                end else begin
                    wr_log.push_back(dif.mem_addr);
                end
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: re=%0d we=%0d addr=%0d, expected no access",
                             dif.mem_re, dif.mem_we, dif.mem_addr);
                end else begin
                    op = exp_q.pop_front();
                    check("op_kind", 32'(dif.mem_we), 32'(op.wr));
                    check("op_addr", 32'(dif.mem_addr), 32'(op.addr));
                    if (op.wr) check("op_wdata", dif.mem_wdata, op.dat);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    int last_wr_cyc = 0;
    int start_cyc   = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [7:0] d);
        dif.reg_sel   = sel;
        dif.reg_wdata = d;
        dif.reg_we    = 1'b1;
        last_wr_cyc   = cyc;
        @(posedge clk);
        #1;
        dif.reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] sel, output logic [7:0] d);
        dif.reg_sel = sel;
        #1;
        d = dif.reg_rdata;
    endtask

    task automatic program_regs(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        reg_write(2'd0, s);
        reg_write(2'd1, d);
        reg_write(2'd2, n);
    endtask

    task automatic do_start();
        reg_write(2'd3, 8'h01);
        start_cyc = last_wr_cyc;
    endtask

    task automatic wait_eop(input int budget, input int prev);
        int n = 0;
        while (eop_cnt == prev && n < budget) begin
            tick(1);
            n++;
        end
        if (eop_cnt == prev) begin
            tests++;
            fails++;
            $display("FAIL eop_timeout: no eop within %0d cycles, expected one", budget);
        end
    endtask

    task automatic load_image(input logic [31:0] seed);
        for (int i = 0; i < 64; i++) init_img[i] = seed ^ (32'h01010101 * 32'(i));
        do_load = 1'b1;
        tick(1);
        do_load = 1'b0;
    endtask

    // Sequential ascending copy: each word read then written, in order.
    task automatic build_model(input logic [7:0] s0, input logic [7:0] d0, input int n);
        logic [7:0]  s;
        logic [7:0]  d;
        logic [31:0] v;
        exp_img = init_img;
        exp_q.delete();
        rd_log.delete();
        wr_log.delete();
        first_re_cyc = -1;
        for (int i = 0; i < n; i++) begin
            s = s0 + 8'(4 * i);
            d = d0 + 8'(4 * i);
            v = exp_img[s[7:2]];
            exp_img[d[7:2]] = v;
            exp_q.push_back('{1'b0, s, 32'd0});
            exp_q.push_back('{1'b1, d, v});
        end
    endtask

    task automatic mem_compare(input string name);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (sram[i] !== exp_img[i]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bus_req"}, 32'(dif.bus_req), 32'd0);
        check({tag, "_mem_re"}, 32'(dif.mem_re), 32'd0);
        check({tag, "_mem_we"}, 32'(dif.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(dif.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, dif.mem_wdata, 32'd0);
        check({tag, "_eop"}, 32'(dif.eop), 32'd0);
        check({tag, "_busy"}, 32'(dif.busy), 32'd0);
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] r;
        reg_read(2'd0, r); check({tag, "_src"}, 32'(r), 32'(e0));
        reg_read(2'd1, r); check({tag, "_dst"}, 32'(r), 32'(e1));
        reg_read(2'd2, r); check({tag, "_len"}, 32'(r), 32'(e2));
        reg_read(2'd3, r); check({tag, "_status"}, 32'(r), 32'(e3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int prev_eop;
        int prev_strobe;
        logic [7:0] r;

        dif.reg_sel   = 2'd0;
        dif.reg_we    = 1'b0;
        dif.reg_wdata = 8'd0;
        dif.bus_gnt   = 1'b1;

        tick(3);
        check_outputs_zero("rst_hold");
        rst = 1'b0;
        check_outputs_zero("rst_rel");
        check_regs("rst_rel", 8'd0, 8'd0, 8'd0, 8'd0);

        // 1) two-word copy, immediate grant; SRAM bytes 128..135 = 1..8
        load_image(32'hA5000000);
        init_img[32] = 32'h04030201;
        init_img[33] = 32'h08070605;
        do_load = 1'b1; tick(1); do_load = 1'b0;
        build_model(8'd128, 8'd192, 2);
        program_regs(8'd128, 8'd192, 8'd2);
        prev_eop = eop_cnt;
        do_start();
        wait_eop(60, prev_eop);
        check("t1_eop_latency", 32'(eop_cyc - start_cyc), 32'd10);
        check("t1_first_read", 32'(first_re_cyc - start_cyc), 32'd2);
        tick(3);
        check("t1_eop_once", 32'(eop_cnt - prev_eop), 32'd1);
        check("t1_wr0", 32'(wr_log[0]), 32'd192);
        check("t1_wr1", 32'(wr_log[1]), 32'd196);
        check("t1_word0", sram[48], 32'h04030201);
        check("t1_word1", sram[49], 32'h08070605);
        mem_compare("t1_mem");
        check("t1_ops_left", 32'(exp_q.size()), 32'd0);
        check_regs("t1_end", 8'd128, 8'd192, 8'd2, 8'h02);

        // 2) LEN=0: eop next cycle, no bus activity
        build_model(8'd8, 8'd16, 0);
        program_regs(8'd8, 8'd16, 8'd0);
        prev_eop = eop_cnt;
        prev_strobe = strobe_cnt;
        do_start();
        wait_eop(10, prev_eop);
        check("t2_eop_latency", 32'(eop_cyc - start_cyc), 32'd1);
        tick(3);
        check("t2_no_strobe", 32'(strobe_cnt - prev_strobe), 32'd0);
        check("t2_eop_once", 32'(eop_cnt - prev_eop), 32'd1);
        reg_read(2'd3, r);
        check("t2_status", 32'(r), 32'h02);

        // 3) grant withheld for 7 cycles
        load_image(32'h3C000000);
        build_model(8'd128, 8'd192, 1);
        program_regs(8'd128, 8'd192, 8'd1);
        dif.bus_gnt = 1'b0;
        prev_eop = eop_cnt;
        do_start();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("t3_req_waiting", 32'(dif.bus_req), 32'd1);
            check("t3_no_re_waiting", 32'(dif.mem_re), 32'd0);
            @(posedge clk);
            #1;
        end
        dif.bus_gnt = 1'b1;
        wait_eop(40, prev_eop);
        check("t3_first_read", 32'(first_re_cyc - start_cyc), 32'd9);
        check("t3_eop_latency", 32'(eop_cyc - start_cyc), 32'(5 * 1 + 7));
        mem_compare("t3_mem");

        // 4) register writes during a transfer are ignored
        load_image(32'h5A000000);
        build_model(8'd128, 8'd192, 4);
        program_regs(8'd128, 8'd192, 8'd4);
        prev_eop = eop_cnt;
        do_start();
        tick(5);
        reg_write(2'd0, 8'd0);
        reg_write(2'd3, 8'h01);
        wait_eop(100, prev_eop);
        check("t4_eop_latency", 32'(eop_cyc - start_cyc), 32'd20);
        tick(3);
        check("t4_eop_once", 32'(eop_cnt - prev_eop), 32'd1);
        mem_compare("t4_mem");
        check("t4_ops_left", 32'(exp_q.size()), 32'd0);
        check_regs("t4_end", 8'd128, 8'd192, 8'd4, 8'h02);

        // 5) source address wrap 252 -> 0
        load_image(32'hC3000000);
        build_model(8'd252, 8'd64, 2);
        program_regs(8'd252, 8'd64, 8'd2);
        prev_eop = eop_cnt;
        do_start();
        wait_eop(60, prev_eop);
        check("t5_rd0", 32'(rd_log[0]), 32'd252);
        check("t5_rd1", 32'(rd_log[1]), 32'd0);
        check("t5_wr0", 32'(wr_log[0]), 32'd64);
        check("t5_wr1", 32'(wr_log[1]), 32'd68);
        check("t5_eop_latency", 32'(eop_cyc - start_cyc), 32'd10);
        mem_compare("t5_mem");

        // 6) reset during WT of word 2 of 4, then a clean restart
        load_image(32'h96000000);
        build_model(8'd128, 8'd192, 0);
        exp_img[48] = init_img[32];
        exp_q.push_back('{1'b0, 8'd128, 32'd0});
        exp_q.push_back('{1'b1, 8'd192, init_img[32]});
        exp_q.push_back('{1'b0, 8'd132, 32'd0});
        program_regs(8'd128, 8'd192, 8'd4);
        prev_eop = eop_cnt;
        do_start();
        tick(7);
        check("t6_reads_before_rst", 32'(rd_log.size()), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        prev_strobe = strobe_cnt;
        check_outputs_zero("t6_after_rst");
        check_regs("t6_after_rst", 8'd0, 8'd0, 8'd0, 8'd0);
        tick(20);
        check("t6_no_strobe", 32'(strobe_cnt - prev_strobe), 32'd0);
        check("t6_no_eop", 32'(eop_cnt - prev_eop), 32'd0);
        check("t6_ops_left", 32'(exp_q.size()), 32'd0);
        mem_compare("t6_mem");

        load_image(32'h0F000000);
        build_model(8'd16, 8'd32, 3);
        program_regs(8'd16, 8'd32, 8'd3);
        prev_eop = eop_cnt;
        do_start();
        wait_eop(80, prev_eop);
        check("t6_restart_latency", 32'(eop_cyc - start_cyc), 32'd15);
        tick(2);
        mem_compare("t6_restart_mem");
        check_regs("t6_restart_end", 8'd16, 8'd32, 8'd3, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Memory-to-memory DMA master that sits beside the CPU on the shared SRAM port, upstream of the bus arbiter/SRAM.
- CPU programs source, destination and length through four byte-wide registers, then writes START.
- The engine copies LEN 32-bit words src→dst in the shared SRAM and pulses eop on completion; this is the eop the top-level bench watches for.

Parameters:
AW, 8, byte address width of SRAM bus (addresses wrap modulo 2^AW)
DW, 32, SRAM data word width
LW, 8, width of word-count register

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
reg_sel  input  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS
reg_we  input  1  CPU register write strobe
reg_wdata  input  8  CPU write data
reg_rdata  output  8  CPU read data (combinational mux on reg_sel)
bus_req  output  1  request for SRAM port
bus_gnt  input  1  grant from arbiter
mem_addr  output  AW  SRAM byte address (low 2 bits always 0)
mem_re  output  1  SRAM read strobe; data valid on mem_rdata next cycle
mem_we  output  1  SRAM write strobe
mem_wdata  output  DW  SRAM write data
mem_rdata  input  DW  SRAM read data
eop  output  1  end-of-process, one-cycle pulse
busy  output  1  transfer in progress

Behaviour:
- Reset: SRC=DST=LEN=0, done=0, state IDLE; bus_req, mem_re, mem_we, eop, busy = 0; mem_addr=0, mem_wdata=0. Reset mid-transfer aborts immediately, with no further SRAM strobes.
- Register writes (reg_we) are accepted only in IDLE; all register writes are ignored while busy.
  - SRC/DST store reg_wdata with bits[1:0] forced to 0.
  - LEN stores the word count.
  - CTRL bit0=1 is START; it clears done. Other bits are ignored.
- reg_rdata: sel0 SRC, sel1 DST, sel2 LEN, sel3 {6'b0, done, busy}.
- Internal working copies: cur_src, cur_dst, cnt. These are loaded from SRC/DST/LEN on START; programmed registers are not modified.
- FSM:
  - IDLE: on START, if LEN==0 go to FIN; else go to REQ with busy=1.
  - REQ: bus_req=1; when bus_gnt=1 is sampled, go to RD.
  - RD: bus_req=1, mem_re=1, mem_addr=cur_src; go to WT.
  - WT: bus_req=1; latch mem_rdata into data reg; go to WR.
  - WR: bus_req=1, mem_we=1, mem_addr=cur_dst, mem_wdata=data reg. Then cur_src+=4 and cur_dst+=4 (mod 2^AW), cnt-=1. If the new cnt==0 go to FIN, else go to GAP.
  - GAP: bus_req=0 for exactly one cycle, so the CPU can win arbitration; go to REQ.
  - FIN: eop=1 for one cycle, done=1, busy=0; go to IDLE.
- Timing:
  - Minimum 5 cycles per word with immediate grant (REQ, RD, WT, WR, GAP); the last word replaces GAP with FIN.
  - LEN=0: eop one cycle after the START write, with no bus activity.
- bus_gnt is sampled only in REQ. The arbiter must hold the grant while bus_req=1; deassertion of grant in RD/WT/WR is a protocol error and is not handled.
- mem_re and mem_we are never asserted in the same cycle.
- Overlap (src/dst ranges intersect) is copied in ascending order; no special handling.
- Address wrap: 252+4 → 0.

Test Plan:
- SRC=128, DST=192, LEN=2, START, gnt tied 1; SRAM[128..135]=1..8 → SRAM[192..199]=1..8. Write order: 192 then 196. eop pulses once, 10 cycles after START (read of 128 on cycle 2). Final status reads 0x02.
- LEN=0, START → eop pulse exactly 1 cycle later; mem_re/mem_we never asserted; done=1.
- SRC=128, DST=192, LEN=1, bus_gnt held 0 for 7 cycles → bus_req high throughout; no mem_re until the cycle after grant is seen; copy still correct.
- Mid-transfer (LEN=4), write SRC=0 and CTRL=1 → both ignored; transfer completes from the original SRC; SRC still reads 128 (the originally programmed value) afterwards.
- SRC=252, DST=64, LEN=2 → reads at 252 then 0; writes at 64, 68.
- Assert rst for 1 cycle during WT of word 2 of 4 → next cycle all outputs 0, registers read 0, no further SRAM writes. A new START then runs cleanly.
